fuzzy_sweep_driver: RTL and testbench

Hardware stimulus/response engine for the type-2 fuzzy controller (`Fuzzy_1`). It drives the two 8-bit crisp inputs across a fixed 17×17 grid and holds each point for a settle window. After the window it samples the defuzzified output and delivers each result with a valid/ready handshake. It sits on the controller's input side and replaces the simulation-only sweep, so on-chip characterisation of the control surface is possible.

---
 rtl/fuzzy_sweep_driver_pkg.sv | 30 +++
 rtl/fuzzy_sweep_driver_if.sv | 27 ++
 rtl/fuzzy_sweep_driver_sweep_grid_counter.sv | 35 +++
 rtl/fuzzy_sweep_driver.sv | 113 +++++++++++
 tb/tb_fuzzy_sweep_driver.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fuzzy_sweep_driver_pkg.sv
// Shared grid constants, FSM encodings and the input clamp
// for the fuzzy controller sweep driver.
package fuzzy_pkg;

  localparam int STEP       = 16;
  localparam int RAW_MAX    = 256;
  localparam int AXIS_PTS   = 17;
  localparam int LO_CLAMP   = 1;
  localparam int HI_CLAMP   = 254;
  localparam int SETTLE_DEF = 14;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_APPLY   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic logic [7:0] clamp8(
    input logic [8:0] raw
  );
    if (raw < 9'(LO_CLAMP))
      return 8'(LO_CLAMP);
    else if (raw > 9'(HI_CLAMP))
      return 8'(HI_CLAMP);
    else
      return raw[7:0];
  endfunction

endpackage

// File: rtl/fuzzy_sweep_driver_if.sv
// Result handshake bundle: one sampled output plus the
// clamped input pair that produced it.
interface fuzzy_sweep_driver_if;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [7:0] res_in1;
  logic [7:0] res_in2;

  modport master (
    output res_valid,
    output res_data,
    output res_in1,
    output res_in2,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_in1,
    input  res_in2,
    output res_ready
  );

endinterface

// File: rtl/fuzzy_sweep_driver_sweep_grid_counter.sv
// Nested 9-bit raw grid counters; j_raw is the inner axis.
// last flags the final (RAW_MAX, RAW_MAX) point.
module sweep_grid_counter
  import fuzzy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output logic [8:0] i_raw,
  output logic [8:0] j_raw,
  output logic       last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_raw <= '0;
      j_raw <= '0;
    end else if (clear) begin
      i_raw <= '0;
      j_raw <= '0;
    end else if (advance) begin
      if (j_raw == 9'(RAW_MAX)) begin
        j_raw <= '0;
        i_raw <= i_raw + 9'(STEP);
      end else begin
        j_raw <= j_raw + 9'(STEP);
      end
    end
  end

  assign last = (i_raw == 9'(RAW_MAX)) &&
                (j_raw == 9'(RAW_MAX));

endmodule

// File: rtl/fuzzy_sweep_driver.sv
// Sweeps the fuzzy controller inputs over a 17x17 grid.
// Optional FUZZY_SWEEP_CHECKSUM_EN adds a running result sum.
module fuzzy_sweep_driver
  import fuzzy_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic       clk_0,
  input  logic       Srst_n,
  input  logic       start,
  input  logic [7:0] saida_defuzzy,
  output logic [7:0] Entrada_01,
  output logic [7:0] Entrada_02,
  output logic       busy,
  output logic       done,
  fuzzy_sweep_driver_if.master res
`ifdef FUZZY_SWEEP_CHECKSUM_EN
  ,
  output logic [15:0] sweep_sum
`endif
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2:0]    state;
  logic [CW-1:0] settle_cnt;
  logic [8:0]    i_raw;
  logic [8:0]    j_raw;
  logic          last;
  logic          go;
  logic          hs;
  logic          advance;

  assign go      = (state == S_IDLE) && start;
  assign hs      = (state == S_HOLD) && res.res_ready;
  assign advance = hs && !last;

  sweep_grid_counter u_grid (
    .clk     (clk_0),
    .rst_n   (Srst_n),
    .clear   (go),
    .advance (advance),
    .i_raw   (i_raw),
    .j_raw   (j_raw),
    .last    (last)
  );

  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      Entrada_01   <= 8'(LO_CLAMP);
      Entrada_02   <= 8'(LO_CLAMP);
      res.res_data <= '0;
      res.res_in1  <= '0;
      res.res_in2  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start)
            state <= S_APPLY;
        end
        S_APPLY: begin
          Entrada_01 <= clamp8(i_raw);
          Entrada_02 <= clamp8(j_raw);
          settle_cnt <= CW'(SETTLE_CYCLES - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0)
            state <= S_CAPTURE;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          res.res_data <= saida_defuzzy;
          res.res_in1  <= Entrada_01;
          res.res_in2  <= Entrada_02;
          state        <= S_HOLD;
        end
        S_HOLD: begin
          if (res.res_ready)
            state <= last ? S_DONE : S_APPLY;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // valid decodes from state so an async reset drops it at once
  assign res.res_valid = (state == S_HOLD);
  assign done          = (state == S_DONE);
  assign busy          = (state != S_IDLE) &&
                         (state != S_DONE);

`ifdef FUZZY_SWEEP_CHECKSUM_EN
  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n)
      sweep_sum <= '0;
    else if (go)
      sweep_sum <= '0;
    else if (hs)
      sweep_sum <= sweep_sum + {8'd0, res.res_data};
  end
`endif

endmodule

// File: tb/tb_fuzzy_sweep_driver.sv
// Directed bench for fuzzy_sweep_driver: sweeps, stall,
// ignored start, mid-sweep reset, optional checksum.
module tb_fuzzy_sweep_driver;

  logic       clk_0 = 1'b0;
  logic       Srst_n;
  logic       start;
  logic [7:0] saida_defuzzy;
  logic [7:0] Entrada_01;
  logic [7:0] Entrada_02;
  logic       busy;
  logic       done;
  bit         const_mode = 1'b0;
`ifdef FUZZY_SWEEP_CHECKSUM_EN
  logic [15:0] sweep_sum;
`endif

  fuzzy_sweep_driver_if res_if ();

  fuzzy_sweep_driver dut (
    .clk_0         (clk_0),
    .Srst_n        (Srst_n),
    .start         (start),
    .saida_defuzzy (saida_defuzzy),
    .Entrada_01    (Entrada_01),
    .Entrada_02    (Entrada_02),
    .busy          (busy),
    .done          (done),
    .res           (res_if)
`ifdef FUZZY_SWEEP_CHECKSUM_EN
    ,
    .sweep_sum     (sweep_sum)
`endif
  );

  always #5 clk_0 = ~clk_0;

  assign saida_defuzzy =
    const_mode ? 8'd200 : (Entrada_01 ^ Entrada_02);

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] q[$];

  always @(posedge clk_0)
    if (Srst_n && res_if.res_valid && res_if.res_ready)
      q.push_back({res_if.res_in1, res_if.res_in2,
                   res_if.res_data});

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cl(input int raw);
    if (raw < 1)   return 8'd1;
    if (raw > 254) return 8'd254;
    return 8'(raw);
  endfunction

  function automatic logic [23:0] exp_entry(input int idx);
    logic [7:0] a;
    logic [7:0] b;
    a = cl((idx / 17) * 16);
    b = cl((idx % 17) * 16);
    return {a, b, a ^ b};
  endfunction

  task automatic verify_sweep(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < q.size(); k++)
      if (q[k] !== exp_entry(k)) bad++;
    check({tag, "_count"}, q.size(), 289);
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk_0);
    start = 1'b1;
    @(negedge clk_0);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 8000) begin
      @(negedge clk_0);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int n;
    int unstable;

    Srst_n = 1'b0;
    start  = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (3) @(negedge clk_0);
    check("rst_e1", Entrada_01, 1);
    check("rst_e2", Entrada_02, 1);
    check("rst_valid", res_if.res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", res_if.res_data, 0);
    Srst_n = 1'b1;
    repeat (2) @(negedge clk_0);

    // sweep 1: no backpressure, stray start during SETTLE
    q.delete();
    pulse_start();
    cyc = 0;
    check("busy_after_start", busy, 1);
    while (!done && cyc < 8000) begin
      @(negedge clk_0);
      cyc++;
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
    end
    check("done_cycle", cyc, 4913);
    check("busy_at_done", busy, 0);
    verify_sweep("sweep1");
    check("first", q[0], {8'd1, 8'd1, 8'd0});
    check("second", q[1], {8'd1, 8'd16, 8'd17});
    check("p17", q[16], {8'd1, 8'd254, 8'd255});
    check("p18", q[17], {8'd16, 8'd1, 8'd17});
    check("last", q[288], {8'd254, 8'd254, 8'd0});
    @(negedge clk_0);
    check("done_pulse_1cyc", done, 0);
    check("idle_e1_kept", Entrada_01, 254);

    // sweep 2: stall 10 cycles at (32,48)
    q.delete();
    pulse_start();
    n = 0;
    while (!(res_if.res_valid && res_if.res_in1 == 8'd32 &&
             res_if.res_in2 == 8'd48) && n < 2000) begin
      @(negedge clk_0);
      n++;
    end
    check("bp_found", n < 2000, 1);
    res_if.res_ready = 1'b0;
    unstable = 0;
    repeat (10) begin
      @(negedge clk_0);
      if (res_if.res_valid !== 1'b1 ||
          res_if.res_data !== 8'd16 ||
          res_if.res_in1 !== 8'd32 ||
          res_if.res_in2 !== 8'd48 ||
          Entrada_01 !== 8'd32 ||
          Entrada_02 !== 8'd48)
        unstable++;
    end
    check("bp_stable", unstable, 0);
    check("bp_data", res_if.res_data, 16);
    check("bp_e2", Entrada_02, 48);
    res_if.res_ready = 1'b1;
    wait_done(cyc);
    check("sweep2_done", done, 1);
    verify_sweep("sweep2");

`ifdef FUZZY_SWEEP_CHECKSUM_EN
    const_mode = 1'b1;
    pulse_start();
    wait_done(cyc);
    check("checksum", sweep_sum, 57800);
    const_mode = 1'b0;
    @(negedge clk_0);
`endif

    // sweep 3: reset while point 100 is pending
    q.delete();
    pulse_start();
    n = 0;
    while (!(res_if.res_valid && q.size() == 100) &&
           n < 3000) begin
      @(negedge clk_0);
      n++;
    end
    check("p100_found", n < 3000, 1);
    check("p100_in1", res_if.res_in1, 80);
    check("p100_in2", res_if.res_in2, 240);
    check("p100_data", res_if.res_data, 160);
    Srst_n = 1'b0;
    #1;
    check("arst_valid", res_if.res_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_e1", Entrada_01, 1);
    @(negedge clk_0);
    Srst_n = 1'b1;
    @(negedge clk_0);
    check("arst_no_accept", q.size(), 100);
    q.delete();
    pulse_start();
    n = 0;
    while (q.size() == 0 && n < 100) begin
      @(negedge clk_0);
      n++;
    end
    check("restart_first", q[0], {8'd1, 8'd1, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
